// File: rtl/sdram_frame_ctrl.sv
// Frame-buffer sequencer for the SDRAM: issues line-burst write/read requests with one outstanding
// at a time, and rotates over NBUF buffers so the display always reads a completed frame.
module sdram_frame_ctrl #(
  parameter int ADDR_W     = 24,
  parameter int ROW_LSB    = 9,
  parameter int LINE_W     = 13,
  parameter int LINES      = 128,
  parameter int FIFO_W     = 11,
  parameter int WR_THRESH  = 512,
  parameter int RD_THRESH  = 512,
  parameter int NBUF       = 2,
  parameter int CONTINUOUS = 1
) (
  input  logic              clk_133M_i,
  input  logic              rst_133i,
  input  logic              vsyn_neg,
  input  logic [FIFO_W-1:0] wr_fifo_used,
  input  logic [FIFO_W-1:0] rd_fifo_used,
  output logic              wr_sdram_req,
  input  logic              wr_sdram_ack,
  output logic [ADDR_W-1:0] wr_sdram_add,
  output logic              rd_sdram_req,
  input  logic              rd_sdram_ack,
  output logic [ADDR_W-1:0] rd_sdram_add,
  output logic              frame_ready,
  output logic              wr_stall,
  output logic              frame_drop
);

  localparam int LW1 = LINE_W + 1;
  localparam logic [LINE_W:0]   LINES_C     = LW1'(LINES);
  localparam logic [LINE_W:0]   LINE_ONE_C  = {{LINE_W{1'b0}}, 1'b1};
  localparam logic [FIFO_W-1:0] WR_TH_C     = FIFO_W'(WR_THRESH);
  localparam logic [FIFO_W-1:0] RD_TH_C     = FIFO_W'(RD_THRESH);
  localparam logic [FIFO_W-1:0] FIFO_FULL_C = {FIFO_W{1'b1}};

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_state_e;

  arb_state_e        state_q, state_d;
  logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] wr_add_q, wr_add_d, rd_add_q, rd_add_d;
  logic [1:0]        wb_q, wb_d, rb_q, rb_d, lb_q, lb_d;
  logic [LINE_W:0]   wline_q, wline_d, rline_q, rline_d;
  logic              rd_active_q, rd_active_d, rd_restart_q, rd_restart_d;
  logic              frame_ready_q, frame_ready_d, wr_stall_q, wr_stall_d, frame_drop_q, frame_drop_d;
  logic              rd_elig_s, wr_elig_s;
  logic [LINE_W:0]   wline_inc_s;
  logic [1:0]        wr_cand_s, stall_cand_s;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [1:0] buf_idx, input logic [LINE_W-1:0] line);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1 -: 2]     = buf_idx;
    a[ROW_LSB +: LINE_W] = line;
    return a;
  endfunction

  // Next write buffer: never the buffer just completed, and (NBUF>=3) never the one being read.
  function automatic logic [1:0] next_buf(input logic [1:0] last, input logic [1:0] rd);
    logic [1:0] c;
    c = 2'd0;
    if (NBUF <= 1) begin
      c = 2'd0;
    end else if (NBUF == 2) begin
      c = (last == 2'd0) ? 2'd1 : 2'd0;
    end else begin
      for (int i = NBUF - 1; i >= 0; i--) begin
        if ((2'(i) != last) && (2'(i) != rd)) c = 2'(i);
        else c = c;
      end
    end
    return c;
  endfunction

  assign rd_elig_s    = rd_active_q && (rline_q < LINES_C) && (rd_fifo_used <= RD_TH_C);
  assign wr_elig_s    = (wline_q < LINES_C) && (wr_fifo_used >= WR_TH_C) && !wr_stall_q &&
                        ((CONTINUOUS != 0) || !frame_ready_q);
  assign wline_inc_s  = wline_q + LINE_ONE_C;
  assign wr_cand_s    = next_buf(wb_q, rb_q);
  assign stall_cand_s = next_buf(lb_q, rb_q);

  // Arbiter next state, request/address generation and buffer bookkeeping.
  always_comb begin
    state_d       = state_q;
    wr_req_d      = wr_req_q;
    rd_req_d      = rd_req_q;
    wr_add_d      = wr_add_q;
    rd_add_d      = rd_add_q;
    wb_d          = wb_q;
    rb_d          = rb_q;
    lb_d          = lb_q;
    wline_d       = wline_q;
    rline_d       = rline_q;
    rd_active_d   = rd_active_q;
    rd_restart_d  = rd_restart_q;
    frame_ready_d = frame_ready_q;
    wr_stall_d    = wr_stall_q;
    frame_drop_d  = frame_drop_q;

    case (state_q)
      ARB_IDLE: begin
        if (rd_elig_s) begin
          state_d  = ARB_RD;
          rd_req_d = 1'b1;
          rd_add_d = make_addr(rb_q, rline_q[LINE_W-1:0]);
        end else if (wr_elig_s) begin
          state_d  = ARB_WR;
          wr_req_d = 1'b1;
          wr_add_d = make_addr(wb_q, wline_q[LINE_W-1:0]);
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WR: begin
        if (wr_sdram_ack) begin
          state_d  = ARB_IDLE;
          wr_req_d = 1'b0;
          if (wline_inc_s == LINES_C) begin
            lb_d          = wb_q;
            frame_ready_d = 1'b1;
            wline_d       = '0;
            if ((NBUF == 2) && (wr_cand_s == rb_q)) wr_stall_d = 1'b1;
            else wb_d = wr_cand_s;
          end else begin
            wline_d = wline_inc_s;
          end
        end else begin
          state_d = ARB_WR;
        end
      end
      ARB_RD: begin
        if (rd_sdram_ack) begin
          state_d      = ARB_IDLE;
          rd_req_d     = 1'b0;
          rd_restart_d = 1'b0;
          // An ack for a burst issued before a frame restart belongs to the old frame.
          if (!rd_restart_q) rline_d = rline_q + LINE_ONE_C;
          else rline_d = rline_q;
        end else begin
          state_d = ARB_RD;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase

    if (wr_stall_q && (rb_q != stall_cand_s)) begin
      wr_stall_d = 1'b0;
      wb_d       = stall_cand_s;
    end else begin
      wr_stall_d = wr_stall_d;
    end

    if (vsyn_neg && frame_ready_q) begin
      rb_d        = lb_q;
      rline_d     = '0;
      rd_active_d = 1'b1;
      if ((state_q == ARB_RD) && !rd_sdram_ack) rd_restart_d = 1'b1;
      else rd_restart_d = 1'b0;
    end else begin
      rd_active_d = rd_active_d;
    end

    if (wr_stall_q && (wr_fifo_used == FIFO_FULL_C)) frame_drop_d = 1'b1;
    else frame_drop_d = frame_drop_d;
  end

  // State registers; reset drops any in-flight request immediately.
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      state_q       <= ARB_IDLE;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      wr_add_q      <= '0;
      rd_add_q      <= '0;
      wb_q          <= 2'd0;
      rb_q          <= 2'd0;
      lb_q          <= 2'd0;
      wline_q       <= '0;
      rline_q       <= '0;
      rd_active_q   <= 1'b0;
      rd_restart_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      wr_stall_q    <= 1'b0;
      frame_drop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_req_q      <= wr_req_d;
      rd_req_q      <= rd_req_d;
      wr_add_q      <= wr_add_d;
      rd_add_q      <= rd_add_d;
      wb_q          <= wb_d;
      rb_q          <= rb_d;
      lb_q          <= lb_d;
      wline_q       <= wline_d;
      rline_q       <= rline_d;
      rd_active_q   <= rd_active_d;
      rd_restart_q  <= rd_restart_d;
      frame_ready_q <= frame_ready_d;
      wr_stall_q    <= wr_stall_d;
      frame_drop_q  <= frame_drop_d;
    end
  end

  assign wr_sdram_req = wr_req_q;
  assign wr_sdram_add = wr_add_q;
  assign rd_sdram_req = rd_req_q;
  assign rd_sdram_add = rd_add_q;
  assign frame_ready  = frame_ready_q;
  assign wr_stall     = wr_stall_q;
  assign frame_drop   = frame_drop_q;

endmodule

// File: tb/tb_sdram_frame_ctrl.sv
// Directed bench: instance 0 is the default build, 1 has three buffers, 2 is single-shot (both 4 lines).
module tb_sdram_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vsyn    [3];
  logic [10:0] wr_used [3];
  logic [10:0] rd_used [3];
  logic        wr_ack  [3];
  logic        rd_ack  [3];
  logic        wr_req  [3];
  logic        rd_req  [3];
  logic [23:0] wr_add  [3];
  logic [23:0] rd_add  [3];
  logic        fr      [3];
  logic        stall   [3];
  logic        drop    [3];

  int checks   = 0;
  int errors   = 0;
  int overlap0 = 0;
  bit saw_stall1 = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdram_frame_ctrl #(
      .LINES      ((g == 0) ? 128 : 4),
      .NBUF       ((g == 1) ? 3 : 2),
      .CONTINUOUS ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk_133M_i   (clk),
      .rst_133i     (rst),
      .vsyn_neg     (vsyn[g]),
      .wr_fifo_used (wr_used[g]),
      .rd_fifo_used (rd_used[g]),
      .wr_sdram_req (wr_req[g]),
      .wr_sdram_ack (wr_ack[g]),
      .wr_sdram_add (wr_add[g]),
      .rd_sdram_req (rd_req[g]),
      .rd_sdram_ack (rd_ack[g]),
      .rd_sdram_add (rd_add[g]),
      .frame_ready  (fr[g]),
      .wr_stall     (stall[g]),
      .frame_drop   (drop[g])
    );
  end

  always @(negedge clk) begin
    if (wr_req[0] && rd_req[0]) overlap0++;
    if (stall[1]) saw_stall1 = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int d, output logic [23:0] add, output bit to);
    to = 1'b1;
    add = '0;
    for (int i = 0; i < 100 && to; i++) begin
      if (wr_req[d]) begin to = 1'b0; add = wr_add[d]; end
      else tick();
    end
  endtask

  task automatic wait_rd(input int d, output logic [23:0] add, output bit to);
    to = 1'b1;
    add = '0;
    for (int i = 0; i < 100 && to; i++) begin
      if (rd_req[d]) begin to = 1'b0; add = rd_add[d]; end
      else tick();
    end
  endtask

  task automatic ack_wr(input int d, input int dly);
    repeat (dly) tick();
    wr_ack[d] = 1'b1;
    tick();
    wr_ack[d] = 1'b0;
  endtask

  task automatic ack_rd(input int d, input int dly);
    repeat (dly) tick();
    rd_ack[d] = 1'b1;
    tick();
    rd_ack[d] = 1'b0;
  endtask

  task automatic pulse_vsyn(input int d);
    vsyn[d] = 1'b1;
    tick();
    vsyn[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [54:0] v;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (wr_req[0] !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b want 0", wr_req[0]); end
    checks++; if (rd_req[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req[0]); end
    checks++; if (wr_add[0] !== 24'h0) begin errors++; $display("FAIL reset_wr_add: got %h want 000000", wr_add[0]); end
    checks++; if ({fr[0], stall[0], drop[0]} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {fr[0], stall[0], drop[0]}); end
    for (int d = 1; d < 3; d++) begin
      v = {wr_req[d], rd_req[d], wr_add[d], rd_add[d], fr[d], stall[d], drop[d]};
      checks++; if (v !== 55'd0) begin errors++; $display("FAIL reset_all[%0d]: got %h want 0", d, v); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_frame();
    logic [23:0] a;
    logic [23:0] exp;
    bit to;
    wr_used[0] = 11'd512;
    for (int l = 0; l < 128; l++) begin
      wait_wr(0, a, to);
      exp = 24'(l) << 9;
      checks++; if (to || a !== exp) begin errors++; $display("FAIL first_frame_addr[%0d]: got %h want %h timeout %0d", l, a, exp, to); end
      if (l == 127) begin
        checks++; if (fr[0] !== 1'b0) begin errors++; $display("FAIL frame_ready_early: got %b want 0", fr[0]); end
      end
      ack_wr(0, 10);
    end
    checks++; if (fr[0] !== 1'b1) begin errors++; $display("FAIL frame_ready_rise: got %b want 1", fr[0]); end
    checks++; if (wr_req[0] !== 1'b0) begin errors++; $display("FAIL write_idle_gap: got %b want 0", wr_req[0]); end
    wait_wr(0, a, to);
    checks++; if (to || a !== 24'h400000) begin errors++; $display("FAIL next_buffer_addr: got %h want 400000 timeout %0d", a, to); end
    wr_used[0] = 11'd0;
    ack_wr(0, 2);
  endtask

  task automatic test_priority();
    rd_used[0] = 11'd1000;
    pulse_vsyn(0);
    tick();
    wr_used[0] = 11'd600;
    rd_used[0] = 11'd100;
    tick();
    checks++; if ({rd_req[0], wr_req[0]} !== 2'b10) begin errors++; $display("FAIL read_wins: got rd,wr=%b want 10", {rd_req[0], wr_req[0]}); end
    checks++; if (rd_add[0] !== 24'h000000) begin errors++; $display("FAIL read_addr: got %h want 000000", rd_add[0]); end
    rd_used[0] = 11'd1000;
    ack_rd(0, 3);
    checks++; if ({rd_req[0], wr_req[0]} !== 2'b00) begin errors++; $display("FAIL idle_after_read: got rd,wr=%b want 00", {rd_req[0], wr_req[0]}); end
    tick();
    checks++; if (wr_req[0] !== 1'b1) begin errors++; $display("FAIL write_after_idle: got %b want 1", wr_req[0]); end
    checks++; if (wr_add[0] !== 24'h400200) begin errors++; $display("FAIL write_addr_after_read: got %h want 400200", wr_add[0]); end
    wr_used[0] = 11'd0;
    ack_wr(0, 2);
  endtask

  task automatic test_stall();
    logic [23:0] a;
    logic [23:0] exp;
    bit to;
    wr_used[0] = 11'd512;
    for (int l = 2; l < 128; l++) begin
      wait_wr(0, a, to);
      exp = 24'h400000 | (24'(l) << 9);
      checks++; if (to || a !== exp) begin errors++; $display("FAIL frame1_addr[%0d]: got %h want %h timeout %0d", l, a, exp, to); end
      ack_wr(0, 1);
    end
    checks++; if (stall[0] !== 1'b1) begin errors++; $display("FAIL stall_set: got %b want 1", stall[0]); end
    checks++; if (drop[0] !== 1'b0) begin errors++; $display("FAIL drop_not_full: got %b want 0", drop[0]); end
    repeat (5) tick();
    checks++; if (wr_req[0] !== 1'b0) begin errors++; $display("FAIL no_write_while_stalled: got %b want 0", wr_req[0]); end
    wr_used[0] = 11'd2047;
    repeat (2) tick();
    checks++; if (drop[0] !== 1'b1) begin errors++; $display("FAIL drop_set: got %b want 1", drop[0]); end
    pulse_vsyn(0);
    checks++; if (stall[0] !== 1'b1) begin errors++; $display("FAIL stall_holds: got %b want 1", stall[0]); end
    tick();
    checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b want 0", stall[0]); end
    wait_wr(0, a, to);
    checks++; if (to || a !== 24'h000000) begin errors++; $display("FAIL wb_after_release: got %h want 000000 timeout %0d", a, to); end
    wr_used[0] = 11'd0;
    ack_wr(0, 1);
  endtask

  task automatic test_vsync_restart();
    logic [23:0] a;
    logic [23:0] exp;
    bit to;
    rd_used[0] = 11'd100;
    for (int l = 0; l < 5; l++) begin
      wait_rd(0, a, to);
      exp = 24'h400000 | (24'(l) << 9);
      checks++; if (to || a !== exp) begin errors++; $display("FAIL read_addr[%0d]: got %h want %h timeout %0d", l, a, exp, to); end
      ack_rd(0, 1);
    end
    wait_rd(0, a, to);
    checks++; if (to || a !== 24'h400A00) begin errors++; $display("FAIL read_line5: got %h want 400a00 timeout %0d", a, to); end
    pulse_vsyn(0);
    repeat (2) tick();
    checks++; if (rd_req[0] !== 1'b1) begin errors++; $display("FAIL read_held: got %b want 1", rd_req[0]); end
    checks++; if (rd_add[0] !== 24'h400A00) begin errors++; $display("FAIL read_addr_held: got %h want 400a00", rd_add[0]); end
    ack_rd(0, 0);
    checks++; if (rd_req[0] !== 1'b0) begin errors++; $display("FAIL read_drop_after_ack: got %b want 0", rd_req[0]); end
    wait_rd(0, a, to);
    checks++; if (to || a !== 24'h400000) begin errors++; $display("FAIL read_restart_line0: got %h want 400000 timeout %0d", a, to); end
    rd_used[0] = 11'd1000;
    ack_rd(0, 1);
  endtask

  task automatic test_no_overlap();
    checks++; if (overlap0 !== 0) begin errors++; $display("FAIL req_overlap: got %0d cycles want 0", overlap0); end
  endtask

  task automatic test_nbuf3();
    int bseq [5] = '{0, 1, 2, 0, 2};
    logic [23:0] a;
    logic [23:0] exp;
    bit to;
    wr_used[1] = 11'd512;
    rd_used[1] = 11'd1000;
    for (int n = 0; n < 17; n++) begin
      wait_wr(1, a, to);
      exp = (24'(bseq[n / 4]) << 22) | (24'(n % 4) << 9);
      checks++; if (to || a !== exp) begin errors++; $display("FAIL nbuf3_addr[%0d]: got %h want %h timeout %0d", n, a, exp, to); end
      if (n == 16) wr_used[1] = 11'd0;
      ack_wr(1, 2);
      if (n == 7) pulse_vsyn(1);
    end
    checks++; if (saw_stall1 !== 1'b0) begin errors++; $display("FAIL nbuf3_no_stall: got %b want 0", saw_stall1); end
  endtask

  task automatic test_single_shot();
    logic [23:0] a;
    logic [23:0] exp;
    bit to;
    int served = 0;
    wr_used[2] = 11'd2047;
    rd_used[2] = 11'd1000;
    for (int n = 0; n < 6; n++) begin
      wait_wr(2, a, to);
      if (!to) begin
        exp = 24'(n) << 9;
        checks++; if (a !== exp) begin errors++; $display("FAIL single_addr[%0d]: got %h want %h", n, a, exp); end
        served++;
        ack_wr(2, 1);
      end
    end
    checks++; if (served !== 4) begin errors++; $display("FAIL single_shot_count: got %0d want 4", served); end
    checks++; if (fr[2] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", fr[2]); end
    checks++; if ({stall[2], drop[2]} !== 2'b00) begin errors++; $display("FAIL drop_without_stall: got stall,drop=%b want 00", {stall[2], drop[2]}); end
  endtask

  task automatic test_reset_midhandshake();
    logic [23:0] a;
    bit to;
    rd_used[0] = 11'd100;
    wait_rd(0, a, to);
    checks++; if (to || a !== 24'h400200) begin errors++; $display("FAIL pre_reset_read: got %h want 400200 timeout %0d", a, to); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (rd_req[0] !== 1'b0) begin errors++; $display("FAIL reset_drops_req: got %b want 0", rd_req[0]); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if ({rd_req[0], fr[0], drop[0]} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b want 000", {rd_req[0], fr[0], drop[0]}); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vsyn[i] = 1'b0;
      wr_used[i] = 11'd0;
      rd_used[i] = 11'd0;
      wr_ack[i] = 1'b0;
      rd_ack[i] = 1'b0;
    end
    test_reset();
    test_first_frame();
    test_priority();
    test_stall();
    test_vsync_restart();
    test_no_overlap();
    test_nbuf3();
    test_single_shot();
    test_reset_midhandshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
